// File: rtl/poly_acc_pkg.sv
// Shared types and modular helpers for the polynomial tile accumulator.
package poly_acc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Helpers operate at the widest supported coefficient width; callers
    // zero-extend their operands and truncate the result back.
    localparam int MAX_DW = 64;

    // (a + b) mod q, assuming a, b < q
    function automatic logic [MAX_DW-1:0] mod_add(input logic [MAX_DW-1:0] a,
                                                  input logic [MAX_DW-1:0] b,
                                                  input logic [MAX_DW-1:0] q);
        logic [MAX_DW:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, q}) begin
            s = s - {1'b0, q};
        end
        return s[MAX_DW-1:0];
    endfunction

    // (a - b) mod q, assuming a, b < q
    function automatic logic [MAX_DW-1:0] mod_sub(input logic [MAX_DW-1:0] a,
                                                  input logic [MAX_DW-1:0] b,
                                                  input logic [MAX_DW-1:0] q);
        logic [MAX_DW:0] s;
        if (a >= b) begin
            s = {1'b0, a} - {1'b0, b};
        end else begin
            s = {1'b0, a} + {1'b0, q} - {1'b0, b};
        end
        return s[MAX_DW-1:0];
    endfunction

    // Parameter sanity: tiles divide the operands, negacyclic folding needs
    // square operands, and the lanes of one tile never wrap onto themselves.
    function automatic bit cfg_ok(input int n_a, input int n_b,
                                  input int tile_a, input int tile_b,
                                  input int dw, input int neg, input int lanes);
        bit ok;
        ok = 1'b1;
        if (tile_a < 1 || tile_b < 1 || lanes < 1) ok = 1'b0;
        if (tile_a >= 1 && (n_a % tile_a) != 0) ok = 1'b0;
        if (tile_b >= 1 && (n_b % tile_b) != 0) ok = 1'b0;
        if (neg != 0 && n_a != n_b) ok = 1'b0;
        if (tile_a + tile_b - 1 > n_a) ok = 1'b0;
        if (dw < 1 || dw > MAX_DW) ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/poly_mod_addsub.sv
// One accumulation lane: y = c (+) x, or c (-) x when sub is set.
module poly_mod_addsub
    import poly_acc_pkg::*;
#(
    parameter int                    DATA_WIDTH = 64,
    parameter logic [DATA_WIDTH-1:0] MODULUS    = 64'hFFFFFFFF00000001
) (
    input  logic [DATA_WIDTH-1:0] c,
    input  logic [DATA_WIDTH-1:0] x,
    input  logic                  sub,
    output logic [DATA_WIDTH-1:0] y
);

    // Negacyclic wrap subtracts; everything else adds.
    assign y = sub ? DATA_WIDTH'(mod_sub(MAX_DW'(c), MAX_DW'(x), MAX_DW'(MODULUS)))
                   : DATA_WIDTH'(mod_add(MAX_DW'(c), MAX_DW'(x), MAX_DW'(MODULUS)));

endmodule

// File: rtl/poly_tile_accumulator.sv
// Accumulates adder-tree tiles into a coefficient buffer, optionally folding
// mod x^N+1, then streams the product out in OUT_LANES-wide beats.
//
// state | meaning
// IDLE  | waiting for start; buffer is clear
// ACCUM | accepting tiles until TOTAL in-range tiles have arrived
// DRAIN | presenting output beats under valid/ready
// DONE  | one-cycle done pulse; buffer cleared for the next product
module poly_tile_accumulator
    import poly_acc_pkg::*;
#(
    parameter int                    N_A        = 128,
    parameter int                    N_B        = 128,
    parameter int                    TILE_A     = 8,
    parameter int                    TILE_B     = 8,
    parameter int                    DATA_WIDTH = 64,
    parameter logic [DATA_WIDTH-1:0] MODULUS    = 64'hFFFFFFFF00000001,
    parameter int                    NEGACYCLIC = 1,
    parameter int                    OUT_LANES  = 8,
    localparam int NTA     = N_A / TILE_A,
    localparam int NTB     = N_B / TILE_B,
    localparam int AIW     = (NTA > 1) ? $clog2(NTA) : 1,
    localparam int BIW     = (NTB > 1) ? $clog2(NTB) : 1,
    localparam int LT      = TILE_A + TILE_B - 1,
    localparam int OUT_LEN = (NEGACYCLIC != 0) ? N_A : N_A + N_B - 1,
    localparam int IXW     = $clog2(OUT_LEN) + 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic                                 tile_valid,
    output logic                                 tile_ready,
    input  logic [AIW-1:0]                       tile_a_idx,
    input  logic [BIW-1:0]                       tile_b_idx,
    input  logic [LT-1:0][DATA_WIDTH-1:0]        tile_data,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [OUT_LANES-1:0][DATA_WIDTH-1:0] out_data,
    output logic [IXW-1:0]                       out_index,
    output logic                                 out_last,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 err
);

    localparam int TOTAL = NTA * NTB;
    localparam int BEATS = (OUT_LEN + OUT_LANES - 1) / OUT_LANES;
    localparam int CW    = $clog2(TOTAL + 1);

    if (!cfg_ok(N_A, N_B, TILE_A, TILE_B, DATA_WIDTH, NEGACYCLIC, OUT_LANES)) begin : g_cfg_err
        $error("poly_tile_accumulator: inconsistent tile/operand parameters");
    end

    state_t                state;
    logic [CW-1:0]         tile_cnt;
    logic [DATA_WIDTH-1:0] coef_q [OUT_LEN];

    logic                  acc_en;
    logic                  in_range;
    logic                  buf_clr;
    int                    tgt    [LT];
    logic                  sub_l  [LT];
    logic [DATA_WIDTH-1:0] rd     [LT];
    logic [DATA_WIDTH-1:0] wr     [LT];

    assign acc_en   = tile_valid & tile_ready;
    assign in_range = (int'(tile_a_idx) < NTA) && (int'(tile_b_idx) < NTB);
    assign buf_clr  = ((state == IDLE) && start) || (state == DONE);

    // Lane target positions, wrap direction and current buffer contents.
    always_comb begin
        int p;
        p = 0;
        for (int j = 0; j < LT; j++) begin
            p        = int'(tile_a_idx) * TILE_A + int'(tile_b_idx) * TILE_B + j;
            tgt[j]   = p;
            sub_l[j] = 1'b0;
            if (NEGACYCLIC != 0 && p >= N_A) begin
                tgt[j]   = p - N_A;
                sub_l[j] = 1'b1;
            end
            rd[j] = '0;
            for (int i = 0; i < OUT_LEN; i++) begin
                if (tgt[j] == i) rd[j] = coef_q[i];
            end
        end
    end

    for (genvar j = 0; j < LT; j++) begin : g_lane
        poly_mod_addsub #(
            .DATA_WIDTH (DATA_WIDTH),
            .MODULUS    (MODULUS)
        ) u_lane (
            .c   (rd[j]),
            .x   (tile_data[j]),
            .sub (sub_l[j]),
            .y   (wr[j])
        );
    end

    // Coefficient buffer: cleared around each product, updated per accepted tile.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < OUT_LEN; i++) coef_q[i] <= '0;
        end else if (buf_clr) begin
            for (int i = 0; i < OUT_LEN; i++) coef_q[i] <= '0;
        end else if (acc_en && in_range) begin
            for (int i = 0; i < OUT_LEN; i++) begin
                for (int j = 0; j < LT; j++) begin
                    if (tgt[j] == i) coef_q[i] <= wr[j];
                end
            end
        end
    end

    // Sequencer with registered handshake/status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            tile_cnt   <= '0;
            tile_ready <= 1'b0;
            out_valid  <= 1'b0;
            out_index  <= '0;
            out_last   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= ACCUM;
                        tile_cnt   <= '0;
                        tile_ready <= 1'b1;
                        busy       <= 1'b1;
                        err        <= 1'b0;
                    end
                end
                ACCUM: begin
                    if (acc_en) begin
                        if (!in_range) begin
                            err <= 1'b1;
                        end else begin
                            tile_cnt <= tile_cnt + CW'(1);
                            if (tile_cnt == CW'(TOTAL - 1)) begin
                                state      <= DRAIN;
                                tile_ready <= 1'b0;
                            end
                        end
                    end
                end
                DRAIN: begin
                    // First cycle lets the final tile settle into the buffer.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        out_index <= '0;
                        out_last  <= (BEATS == 1);
                    end else if (out_ready) begin
                        if (out_last) begin
                            state     <= DONE;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            out_index <= '0;
                            done      <= 1'b1;
                        end else begin
                            out_index <= out_index + IXW'(OUT_LANES);
                            out_last  <= (int'(out_index) + OUT_LANES == (BEATS - 1) * OUT_LANES);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Beat mux: positions past OUT_LEN read as zero; nothing shown outside DRAIN.
    always_comb begin
        for (int l = 0; l < OUT_LANES; l++) begin
            out_data[l] = '0;
            if (out_valid) begin
                for (int i = 0; i < OUT_LEN; i++) begin
                    if (int'(out_index) + l == i) out_data[l] = coef_q[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_poly_tile_accumulator.sv
// Randomised bench for poly_tile_accumulator against a coefficient-array model.
// Three instances share the tile/output stimulus; only the one that was started
// responds. mode 0: linear N=8, mode 1: negacyclic N=8, mode 2: linear N=12.
module tb_poly_tile_accumulator;

    localparam int DW = 8;
    localparam int Q  = 17;
    localparam int LT = 7;
    localparam int OL = 4;

    logic clk;
    logic rst;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic                 start0, start1, start2;
    logic                 tile_valid, out_ready;
    logic [1:0]           a_idx, b_idx;
    logic [LT-1:0][DW-1:0] tile_data;

    logic tr0, ov0, ol0, bz0, dn0, er0;
    logic tr1, ov1, ol1, bz1, dn1, er1;
    logic tr2, ov2, ol2, bz2, dn2, er2;
    logic [OL-1:0][DW-1:0] od0, od1, od2;
    logic [4:0] oi0;
    logic [3:0] oi1;
    logic [5:0] oi2;

    poly_tile_accumulator #(.N_A(8), .N_B(8), .TILE_A(4), .TILE_B(4), .DATA_WIDTH(DW),
        .MODULUS(8'd17), .NEGACYCLIC(0), .OUT_LANES(OL)) dut_lin (
        .clk(clk), .rst(rst), .start(start0), .tile_valid(tile_valid), .tile_ready(tr0),
        .tile_a_idx(a_idx[0:0]), .tile_b_idx(b_idx[0:0]), .tile_data(tile_data),
        .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .out_index(oi0),
        .out_last(ol0), .busy(bz0), .done(dn0), .err(er0));

    poly_tile_accumulator #(.N_A(8), .N_B(8), .TILE_A(4), .TILE_B(4), .DATA_WIDTH(DW),
        .MODULUS(8'd17), .NEGACYCLIC(1), .OUT_LANES(OL)) dut_neg (
        .clk(clk), .rst(rst), .start(start1), .tile_valid(tile_valid), .tile_ready(tr1),
        .tile_a_idx(a_idx[0:0]), .tile_b_idx(b_idx[0:0]), .tile_data(tile_data),
        .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .out_index(oi1),
        .out_last(ol1), .busy(bz1), .done(dn1), .err(er1));

    poly_tile_accumulator #(.N_A(12), .N_B(12), .TILE_A(4), .TILE_B(4), .DATA_WIDTH(DW),
        .MODULUS(8'd17), .NEGACYCLIC(0), .OUT_LANES(OL)) dut_wide (
        .clk(clk), .rst(rst), .start(start2), .tile_valid(tile_valid), .tile_ready(tr2),
        .tile_a_idx(a_idx), .tile_b_idx(b_idx), .tile_data(tile_data),
        .out_valid(ov2), .out_ready(out_ready), .out_data(od2), .out_index(oi2),
        .out_last(ol2), .busy(bz2), .done(dn2), .err(er2));

    int   mode;
    logic obs_tr, obs_ov, obs_ol, obs_bz, obs_dn, obs_er;
    int   obs_index;
    int   obs_data [OL];

    // Outputs of whichever instance is under test.
    always_comb begin
        obs_tr = tr0; obs_ov = ov0; obs_ol = ol0; obs_bz = bz0; obs_dn = dn0; obs_er = er0;
        obs_index = int'(oi0);
        for (int l = 0; l < OL; l++) obs_data[l] = int'(od0[l]);
        if (mode == 1) begin
            obs_tr = tr1; obs_ov = ov1; obs_ol = ol1; obs_bz = bz1; obs_dn = dn1; obs_er = er1;
            obs_index = int'(oi1);
            for (int l = 0; l < OL; l++) obs_data[l] = int'(od1[l]);
        end else if (mode == 2) begin
            obs_tr = tr2; obs_ov = ov2; obs_ol = ol2; obs_bz = bz2; obs_dn = dn2; obs_er = er2;
            obs_index = int'(oi2);
            for (int l = 0; l < OL; l++) obs_data[l] = int'(od2[l]);
        end
    end

    int vectors;
    int miscompares;
    int model_c [32];
    int rx      [32];
    int tl      [3][3][LT];
    int exp2    [16];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        if (obs !== expv) begin
            miscompares++;
            $display("FAIL %s: observed %0d expected %0d (mode %0d, t=%0t)", tag, obs, expv, mode, $time);
        end
    endtask

    function automatic int n_of(input int m);
        return (m == 2) ? 12 : 8;
    endfunction

    function automatic int len_of(input int m);
        return (m == 1) ? 8 : 2 * n_of(m) - 1;
    endfunction

    task automatic idle_check(input string tag);
        check({tag, "_tile_ready"}, obs_tr, 0);
        check({tag, "_out_valid"}, obs_ov, 0);
        check({tag, "_out_last"}, obs_ol, 0);
        check({tag, "_out_index"}, obs_index, 0);
        check({tag, "_busy"}, obs_bz, 0);
        check({tag, "_done"}, obs_dn, 0);
        check({tag, "_err"}, obs_er, 0);
        for (int l = 0; l < OL; l++) check({tag, "_out_data"}, obs_data[l], 0);
    endtask

    task automatic clear_tl();
        for (int a = 0; a < 3; a++)
            for (int b = 0; b < 3; b++)
                for (int j = 0; j < LT; j++) tl[a][b][j] = 0;
    endtask

    task automatic start_run(input int m);
        mode = m;
        for (int i = 0; i < 32; i++) begin model_c[i] = 0; rx[i] = -1; end
        start0 = (m == 0); start1 = (m == 1); start2 = (m == 2);
        @(negedge clk);
        start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
        check("start_tile_ready", obs_tr, 1);
        check("start_busy", obs_bz, 1);
        check("start_err_clear", obs_er, 0);
    endtask

    // Present one tile, wait for acceptance, and fold it into the model.
    task automatic send_tile(input int a, input int b, input int lanes [LT]);
        int waited;
        int n;
        int p;
        n = n_of(mode);
        a_idx = 2'(a);
        b_idx = 2'(b);
        for (int j = 0; j < LT; j++) tile_data[j] = DW'(lanes[j]);
        tile_valid = 1'b1;
        waited = 0;
        while (!obs_tr && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!obs_tr) begin
            check("tile_accept_timeout", 0, 1);
        end else if (a < n / 4 && b < n / 4) begin
            for (int j = 0; j < LT; j++) begin
                p = a * 4 + b * 4 + j;
                if (mode == 1 && p >= n) model_c[p - n] = (model_c[p - n] - lanes[j] + Q) % Q;
                else                     model_c[p]     = (model_c[p] + lanes[j]) % Q;
            end
        end
        @(negedge clk);
        tile_valid = 1'b0;
    endtask

    // Collect every beat, checking contents each cycle it is shown.
    task automatic drain(input int stall_beat, input int stall_len);
        int len, beats, k, stall, cyc, e;
        len   = len_of(mode);
        beats = (len + OL - 1) / OL;
        k     = 0;
        stall = stall_len;
        cyc   = 0;
        while (k < beats && cyc < 200) begin
            out_ready = !(k == stall_beat && stall > 0);
            if (obs_ov) begin
                check("out_index", obs_index, k * OL);
                for (int l = 0; l < OL; l++) begin
                    e = (k * OL + l < len) ? model_c[k * OL + l] : 0;
                    check("out_data", obs_data[l], e);
                end
                check("out_last", obs_ol, (k == beats - 1));
                if (out_ready) begin
                    for (int l = 0; l < OL; l++) rx[k * OL + l] = obs_data[l];
                    k++;
                end else begin
                    stall--;
                end
            end
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
        check("beats_accepted", k, beats);
        check("done_pulse", obs_dn, 1);
        check("valid_after_last", obs_ov, 0);
        @(negedge clk);
        check("done_one_cycle", obs_dn, 0);
        check("busy_after_done", obs_bz, 0);
    endtask

    task automatic run(input int m, input bit fixed, input bit inject_bad,
                       input int stall_beat, input int stall_len);
        int nt, total, r, t;
        int ord_a [9];
        int ord_b [9];
        int lanes [LT];
        bit bad;
        start_run(m);
        nt = n_of(m) / 4;
        total = nt * nt;
        for (int i = 0; i < total; i++) begin
            ord_a[i] = i / nt;
            ord_b[i] = i % nt;
            if (!fixed)
                for (int j = 0; j < LT; j++) tl[ord_a[i]][ord_b[i]][j] = int'($urandom_range(0, Q - 1));
        end
        for (int i = total - 1; i > 0; i--) begin
            r = int'($urandom_range(0, i));
            t = ord_a[i]; ord_a[i] = ord_a[r]; ord_a[r] = t;
            t = ord_b[i]; ord_b[i] = ord_b[r]; ord_b[r] = t;
        end
        bad = 1'b0;
        if (inject_bad) begin
            for (int j = 0; j < LT; j++) lanes[j] = int'($urandom_range(1, Q - 1));
            if ($urandom_range(0, 1) == 1) send_tile(3, int'($urandom_range(0, 2)), lanes);
            else                           send_tile(int'($urandom_range(0, 2)), 3, lanes);
            bad = 1'b1;
            check("err_set", obs_er, 1);
            check("ready_after_bad", obs_tr, 1);
        end
        for (int i = 0; i < total; i++) begin
            for (int j = 0; j < LT; j++) lanes[j] = tl[ord_a[i]][ord_b[i]][j];
            send_tile(ord_a[i], ord_b[i], lanes);
            check("tile_ready_after_tile", obs_tr, (i < total - 1));
            check("no_early_drain", obs_ov, 0);
            check("err_sticky", obs_er, bad);
        end
        drain(stall_beat, stall_len);
        check("err_after_done", obs_er, bad);
    endtask

    initial begin
        int lanes [LT];
        vectors = 0;
        miscompares = 0;
        mode = 0;
        rst = 1'b0;
        start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
        tile_valid = 1'b0;
        out_ready = 1'b0;
        a_idx = '0; b_idx = '0; tile_data = '0;
        exp2 = '{1, 2, 3, 4, 5, 6, 7, 8, 7, 6, 5, 4, 3, 2, 1, 0};
        clear_tl();

        repeat (3) @(negedge clk);
        for (int m = 0; m < 3; m++) begin
            mode = m;
            #1 idle_check("reset");
        end
        rst = 1'b1;
        @(negedge clk);

        // Reset mid-accumulation, then a clean product.
        start_run(1);
        for (int t = 0; t < 2; t++) begin
            for (int j = 0; j < LT; j++) lanes[j] = int'($urandom_range(1, Q - 1));
            send_tile(t, t, lanes);
        end
        rst = 1'b0;
        #1 idle_check("mid_reset");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run(1, 1'b0, 1'b0, -1, 0);

        // Linear ramp pattern.
        for (int a = 0; a < 2; a++)
            for (int b = 0; b < 2; b++)
                for (int j = 0; j < LT; j++) tl[a][b][j] = (j < 4) ? j + 1 : 7 - j;
        run(0, 1'b1, 1'b0, -1, 0);
        for (int i = 0; i < 16; i++) check("ramp_coef", rx[i], exp2[i]);

        // Negacyclic wrap of x^8 to -1.
        clear_tl();
        tl[1][1][0] = 1;
        run(1, 1'b1, 1'b0, -1, 0);
        check("wrap_c0", rx[0], 16);
        for (int i = 1; i < 8; i++) check("wrap_rest", rx[i], 0);

        // Two contributions of 10 at one position.
        clear_tl();
        tl[0][1][0] = 10;
        tl[1][0][0] = 10;
        run(0, 1'b1, 1'b0, -1, 0);
        check("mod_overflow_c4", rx[4], 3);

        // Backpressure for 5 cycles on beat 1.
        run(0, 1'b0, 1'b0, 1, 5);

        // Out-of-range tile, then a run where err must clear on start.
        run(2, 1'b0, 1'b1, 2, 3);
        run(2, 1'b0, 1'b0, -1, 0);

        for (int it = 0; it < 8; it++) begin
            int m;
            m = int'($urandom_range(0, 2));
            run(m, 1'b0, (m == 2) && ($urandom_range(0, 1) == 1),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 4)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
